// File: rtl/interleaver_commutator_ctrl.sv
// Commutator controller for the byte-wide convolutional interleaver.
// Walks a branch pointer across the delay branches, enables the selected
// branch shift, muxes its oldest byte to the output and tracks sync lock.
module interleaver_commutator_ctrl #(
  parameter int unsigned NUM_BRANCH = 12,
  parameter int unsigned DATA_W     = 8,
  parameter int unsigned PKT_LEN    = 204,
  parameter int unsigned MISS_LIMIT = 3
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         in_valid,
  input  logic [DATA_W-1:0]            in_data,
  input  logic                         in_sync,
  input  logic [NUM_BRANCH*DATA_W-1:0] branch_q,
  output logic [NUM_BRANCH-1:0]        branch_en,
  output logic [DATA_W-1:0]            branch_d,
  output logic                         out_valid,
  output logic [DATA_W-1:0]            out_data,
  output logic                         out_sync,
  output logic                         locked,
  output logic                         sync_err
);

  localparam int unsigned IDX_W  = (NUM_BRANCH > 1) ? $clog2(NUM_BRANCH) : 1;
  localparam int unsigned CNT_W  = (PKT_LEN > 1) ? $clog2(PKT_LEN) : 1;
  localparam int unsigned MISS_W = $clog2(MISS_LIMIT + 1);

  localparam logic [0:0] ST_HUNT = 1'b0;
  localparam logic [0:0] ST_LOCK = 1'b1;

  logic [0:0]        state_q, state_d;
  logic [IDX_W-1:0]  idx_q, idx_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [MISS_W-1:0] miss_q, miss_d;
  logic              out_valid_q, out_valid_d;
  logic [DATA_W-1:0] out_data_q, out_data_d;
  logic              out_sync_q, out_sync_d;
  logic              locked_q, locked_d;
  logic              sync_err_q, sync_err_d;

  logic              accept;
  logic              sync_miss;
  logic              sync_slip;
  logic [IDX_W-1:0]  eff_idx;
  logic [CNT_W-1:0]  eff_cnt;
  logic [DATA_W-1:0] sel_data;

  assign branch_d  = in_data;
  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;
  assign out_sync  = out_sync_q;
  assign locked    = locked_q;
  assign sync_err  = sync_err_q;

  // Accept decision, effective pointer (a sync byte restarts the packet) and output mux
  always_comb begin
    accept    = in_valid && ((state_q == ST_LOCK) || in_sync);
    sync_miss = (state_q == ST_LOCK) && in_valid && !in_sync && (cnt_q == '0);
    sync_slip = (state_q == ST_LOCK) && in_valid && in_sync && (cnt_q != '0);
    eff_idx   = in_sync ? '0 : idx_q;
    eff_cnt   = in_sync ? '0 : cnt_q;
    sel_data  = in_data;
    for (int j = 0; j < int'(NUM_BRANCH); j++) begin
      if (eff_idx == IDX_W'(j)) begin
        sel_data = branch_q[j*DATA_W +: DATA_W];
      end
    end
    if (eff_idx == '0) begin
      sel_data = in_data;
    end
  end

  // One-hot shift enable for the selected delay branch; branch 0 has no buffer
  always_comb begin
    branch_en = '0;
    for (int j = 1; j < int'(NUM_BRANCH); j++) begin
      branch_en[j] = reset && accept && (eff_idx == IDX_W'(j));
    end
  end

  // Next-state: pointer/counter advance, lock FSM and registered outputs
  always_comb begin
    state_d     = state_q;
    idx_d       = idx_q;
    cnt_d       = cnt_q;
    miss_d      = miss_q;
    out_valid_d = 1'b0;
    out_data_d  = out_data_q;
    out_sync_d  = 1'b0;
    sync_err_d  = sync_miss || sync_slip;

    if (accept) begin
      out_valid_d = 1'b1;
      out_data_d  = sel_data;
      out_sync_d  = (eff_cnt == '0);
      idx_d       = (eff_idx == IDX_W'(NUM_BRANCH - 1)) ? '0 : eff_idx + IDX_W'(1);
      cnt_d       = (eff_cnt == CNT_W'(PKT_LEN - 1)) ? '0 : eff_cnt + CNT_W'(1);
    end

    case (state_q)
      ST_HUNT: begin
        if (accept) begin
          state_d = ST_LOCK;
          miss_d  = '0;
        end
      end
      default: begin
        if (in_valid) begin
          if (in_sync) begin
            miss_d = '0;
          end else if (cnt_q == '0) begin
            if (miss_q == MISS_W'(MISS_LIMIT - 1)) begin
              state_d = ST_HUNT;
              idx_d   = '0;
              cnt_d   = '0;
              miss_d  = '0;
            end else begin
              miss_d = miss_q + MISS_W'(1);
            end
          end
        end
      end
    endcase

    locked_d = (state_d == ST_LOCK);
  end

  // State and output registers with synchronous active-low reset
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q     <= ST_HUNT;
      idx_q       <= '0;
      cnt_q       <= '0;
      miss_q      <= '0;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      out_sync_q  <= 1'b0;
      locked_q    <= 1'b0;
      sync_err_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      idx_q       <= idx_d;
      cnt_q       <= cnt_d;
      miss_q      <= miss_d;
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
      out_sync_q  <= out_sync_d;
      locked_q    <= locked_d;
      sync_err_q  <= sync_err_d;
    end
  end

endmodule

// File: tb/tb_interleaver_commutator_ctrl.sv
// Self-checking bench for interleaver_commutator_ctrl: ideal branch buffers
// around the DUT plus a reference model feeding an output scoreboard.
module tb_interleaver_commutator_ctrl;

  localparam int unsigned NB    = 12;
  localparam int unsigned DW    = 8;
  localparam int unsigned PL    = 204;
  localparam int unsigned ML    = 3;
  localparam int unsigned STG   = 17;
  localparam int unsigned DEPTH = (NB - 1) * STG;

  logic              clk = 1'b0;
  logic              reset = 1'b0;
  logic              in_valid = 1'b0;
  logic [DW-1:0]     in_data = '0;
  logic              in_sync = 1'b0;
  logic [NB*DW-1:0]  branch_q;
  logic [NB-1:0]     branch_en;
  logic [DW-1:0]     branch_d;
  logic              out_valid;
  logic [DW-1:0]     out_data;
  logic              out_sync;
  logic              locked;
  logic              sync_err;

  interleaver_commutator_ctrl #(
    .NUM_BRANCH(NB), .DATA_W(DW), .PKT_LEN(PL), .MISS_LIMIT(ML)
  ) dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_data(in_data),
    .in_sync(in_sync), .branch_q(branch_q), .branch_en(branch_en),
    .branch_d(branch_d), .out_valid(out_valid), .out_data(out_data),
    .out_sync(out_sync), .locked(locked), .sync_err(sync_err)
  );

  always #5 clk = ~clk;

  // Ideal branch buffers: branch j is j*17 bytes deep, shifted by branch_en
  logic [DW-1:0] mem [NB][DEPTH] = '{default: '{default: 8'h00}};

  always @(posedge clk) begin
    for (int j = 1; j < int'(NB); j++) begin
      if (branch_en[j]) begin
        for (int k = j*STG - 1; k >= 1; k--) mem[j][k] <= mem[j][k-1];
        mem[j][0] <= branch_d;
      end
    end
  end

  always_comb begin
    branch_q = '0;
    for (int j = 1; j < int'(NB); j++) branch_q[j*DW +: DW] = mem[j][j*STG - 1];
  end

  int n_cmp = 0;
  int n_err = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Reference model state
  logic [DW-1:0] mline [NB][$];
  logic [DW:0]   sb [$];
  bit            m_lock = 0;
  int            m_idx = 0;
  int            m_cnt = 0;
  int            m_miss = 0;
  logic [NB-1:0] en_seen;
  int            errs_seen = 0;

  // One clock of stimulus: predict, drive, check comb outputs, then check registered outputs
  task automatic drive(input logic rn, input logic v, input logic [DW-1:0] d, input logic s);
    bit            acc, err, miss_ev;
    int            ei, ec;
    logic [NB-1:0] exp_en;
    logic [DW-1:0] eo;
    logic [DW:0]   got_e;
    exp_en = '0;
    acc = 0;
    err = 0;
    if (rn) begin
      acc     = v && (m_lock || s);
      err     = m_lock && v && (s ? (m_cnt != 0) : (m_cnt == 0));
      miss_ev = m_lock && v && !s && (m_cnt == 0);
      ei = (acc && s) ? 0 : m_idx;
      ec = (acc && s) ? 0 : m_cnt;
      if (acc) begin
        if (ei != 0) exp_en[ei] = 1'b1;
        if (ei == 0) eo = d;
        else begin
          mline[ei].push_back(d);
          eo = mline[ei].pop_front();
        end
        sb.push_back({eo, (ec == 0)});
        m_idx = (ei == int'(NB) - 1) ? 0 : ei + 1;
        m_cnt = (ec == int'(PL) - 1) ? 0 : ec + 1;
      end
      if (!m_lock && acc) begin
        m_lock = 1;
        m_miss = 0;
      end else if (m_lock && v && s) begin
        m_miss = 0;
      end else if (miss_ev) begin
        m_miss++;
        if (m_miss == int'(ML)) begin
          m_lock = 0; m_idx = 0; m_cnt = 0; m_miss = 0;
        end
      end
    end else begin
      m_lock = 0; m_idx = 0; m_cnt = 0; m_miss = 0;
      sb.delete();
    end

    @(negedge clk);
    reset = rn; in_valid = v; in_data = d; in_sync = s;
    #1;
    en_seen = branch_en;
    check_eq("branch_en", 32'(branch_en), 32'(exp_en));
    check_eq("branch_d", 32'(branch_d), 32'(d));
    @(posedge clk);
    #1;
    check_eq("out_valid", 32'(out_valid), 32'(acc));
    check_eq("sync_err", 32'(sync_err), 32'(err));
    check_eq("locked", 32'(locked), 32'(m_lock));
    if (sync_err) errs_seen++;
    if (!rn) begin
      check_eq("rst_out_data", 32'(out_data), 32'h0);
      check_eq("rst_out_sync", 32'(out_sync), 32'h0);
    end
    if (out_valid) begin
      check_eq("sb_size", 32'(sb.size() > 0), 32'h1);
      if (sb.size() > 0) begin
        got_e = sb.pop_front();
        check_eq("out_data", 32'(out_data), 32'(got_e[DW:1]));
        check_eq("out_sync", 32'(out_sync), 32'(got_e[0]));
      end
    end
  endtask

  function automatic logic [DW-1:0] stream_byte(input int pos, input bit s);
    return s ? 8'h47 : 8'(pos);
  endfunction

  initial begin
    int pos;
    int pkt_start;
    bit s;
    for (int j = 0; j < int'(NB); j++)
      for (int k = 0; k < j*int'(STG); k++) mline[j].push_back(8'h00);

    // Reset, then idle
    drive(0, 0, 8'h00, 0);
    drive(0, 0, 8'h00, 0);
    for (int i = 0; i < 5; i++) drive(1, 0, 8'h00, 0);

    // Hunt: non-sync bytes dropped, sync byte locks
    drive(1, 1, 8'h11, 0);
    drive(1, 1, 8'h22, 0);
    drive(1, 1, 8'h47, 1);
    check_eq("hunt_sync_data", 32'(out_data), 32'h47);
    check_eq("hunt_locked", 32'(locked), 32'h1);

    // Locked counting stream, syncs on packet boundaries
    for (pos = 1; pos < 712; pos++) begin
      s = (pos % PL) == 0;
      drive(1, 1, stream_byte(pos, s), s);
      if (pos <= 204 && (pos % NB) == 1) check_eq("branch1_empty", 32'(out_data), 32'h0);
      if (pos == 205) check_eq("first_delayed", 32'(out_data), 32'h01);
    end

    // Misplaced sync at packet offset 100 restarts the packet
    drive(1, 1, 8'h47, 1);
    check_eq("slip_err", 32'(sync_err), 32'h1);
    check_eq("slip_out_sync", 32'(out_sync), 32'h1);
    pkt_start = 712;
    pos = 713;
    drive(1, 1, stream_byte(pos, 0), 0);
    check_eq("slip_next_en", 32'(en_seen), 32'h002);
    for (pos = 714; pos < 1120; pos++) begin
      s = ((pos - pkt_start) % PL) == 0;
      if (pos % 37 == 0) drive(1, 0, 8'h00, 0);
      drive(1, 1, stream_byte(pos, s), s);
    end

    // Syncs stop: three misses then lock is lost
    errs_seen = 0;
    for (pos = 1120; pos < 1120 + 3*int'(PL) + 10; pos++) drive(1, 1, stream_byte(pos, 0), 0);
    check_eq("miss_errs", 32'(errs_seen), 32'd3);
    check_eq("miss_unlocked", 32'(locked), 32'h0);

    // Relock, reset mid-packet with valid high, relock again
    drive(1, 1, 8'h47, 1);
    for (int i = 1; i < 50; i++) drive(1, 1, 8'(i), 0);
    drive(0, 1, 8'h33, 0);
    check_eq("midrst_en", 32'(en_seen), 32'h0);
    check_eq("midrst_locked", 32'(locked), 32'h0);
    drive(1, 0, 8'h00, 0);
    drive(1, 1, 8'h47, 1);
    check_eq("relock_sync", 32'(out_sync), 32'h1);
    drive(1, 1, 8'h01, 0);
    check_eq("relock_en", 32'(en_seen), 32'h002);
    for (int i = 2; i < 30; i++) drive(1, 1, 8'(i), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/interleaver_commutator_ctrl.md
Name: interleaver_commutator_ctrl

Overview:
Input/output commutator controller for the byte-wide convolutional interleaver.
- Steps a branch pointer across NUM_BRANCH parallel delay branches, one byte per step. Branch j is built from j chained 17-stage 8-bit shift buffers; branch 0 is a zero-delay path.
- Raises the per-branch shift enable for the selected branch and muxes that branch's oldest byte to the output.
- Keeps the commutator phase locked to transport-packet sync bytes.

Parameters:
NUM_BRANCH, 12, number of interleaver branches (branch 0 = no delay).
DATA_W, 8, byte width.
PKT_LEN, 204, bytes per packet; expected sync spacing.
MISS_LIMIT, 3, consecutive missing syncs before lock is dropped.

Ports:
clk  in  1  system clock, all state on rising edge.
reset  in  1  synchronous, active-low reset.
in_valid  in  1  in_data/in_sync valid this cycle; no backpressure.
in_data  in  DATA_W  input byte.
in_sync  in  1  in_data is a packet sync byte.
branch_q  in  NUM_BRANCH*DATA_W  oldest byte of each branch; slice j = branch j; slice 0 ignored.
branch_en  out  NUM_BRANCH  one-hot shift enable to branch buffers; combinational.
branch_d  out  DATA_W  data broadcast to all branch inputs (= in_data).
out_valid  out  1  out_data/out_sync valid.
out_data  out  DATA_W  interleaved output byte.
out_sync  out  1  out_data is the packet-start byte.
locked  out  1  commutator phase aligned to sync.
sync_err  out  1  one-cycle pulse on sync misplacement or absence.

Behaviour:
- Reset (reset=0 at a clock edge) values:
  - out_valid=0, out_data=0, out_sync=0, locked=0, sync_err=0.
  - Branch pointer idx=0, byte count cnt=0, miss count=0, state HUNT.
- branch_d = in_data at all times.
- Accepted byte = in_valid=1 in state LOCK, or in_valid=1 && in_sync=1 in state HUNT.
- branch_en[idx] = 1 only when an accepted byte is present and idx != 0; all other bits are 0. branch_en bit 0 is always 0.
- Output timing: 1-cycle latency. At the edge after an accepted byte:
  - out_valid=1.
  - out_data = in_data if idx==0, else branch_q[idx] as sampled before that edge's shift.
  - out_sync = 1 iff the accepted byte had cnt==0.
- out_valid=0 in every cycle with no accepted byte; out_data holds its last value.
- Pointer and counter on each accepted byte:
  - idx <= (idx==NUM_BRANCH-1) ? 0 : idx+1.
  - cnt <= (cnt==PKT_LEN-1) ? 0 : cnt+1.
- PKT_LEN must be a multiple of NUM_BRANCH, so a sync byte always lands on branch 0.
- FSM HUNT:
  - Bytes without in_sync are dropped: no branch_en, no output.
  - On in_valid && in_sync: accept the byte with idx=0, cnt=0; go to LOCK; locked=1 from the next cycle.
- FSM LOCK:
  - Sync at cnt==0: miss count cleared.
  - Sync at cnt!=0:
    - sync_err pulses.
    - The byte is re-treated as packet start: idx forced to 0, cnt to 0, then both advance normally.
    - out_sync=1 for that byte; branch_en[0] stays 0.
    - Miss count cleared.
  - No sync at cnt==0 (valid byte):
    - sync_err pulses and miss count increments.
    - The byte is processed normally.
    - When miss count reaches MISS_LIMIT, go to HUNT at the next edge, with locked=0 and idx=cnt=0.
- Branch contents are never cleared by this block. They reset to 0 on their own, so output from branch j is 0 until j*17 revisits of that branch.
- Reset mid-operation: all above state returns to reset values at that edge; branch_en=0 while reset=0.
- Gaps in in_valid freeze idx, cnt, FSM and branch contents.

Test Plan:
- Reset, in_valid=0 for 5 cycles -> out_valid=0, locked=0, branch_en=0 throughout.
- In HUNT, bytes 0x11,0x22 without sync, then 0x47 with in_sync -> first two dropped. 0x47 appears one cycle later with out_sync=1, and locked=1.
- Locked, contiguous counting stream starting 0x47 (sync), 0x01, 0x02, ... with an ideal branch model:
  - branch_en walks 0,2,4,...,0x800 cyclically, with bit 0 never set.
  - The byte at stream index 1 emerges at output index 1+17*12=205.
  - Output indices 1..204 that come from branch 1 are 0x00.
- Sync at stream index 100 -> sync_err pulse, out_sync=1 on that byte, next byte drives branch_en=0x002.
- Stop asserting in_sync for 3 packets -> sync_err pulses at cnt==0 three times; locked falls after the third.
- Reset asserted mid-packet with in_valid=1 -> at the next edge out_valid=0, branch_en=0, locked=0. A sync afterwards relocks with idx=0.
